// File: rtl/pll_lock_ctrl.sv
// PLL power-up/reset sequencer and lock supervisor.
// Runs on the PLL reference clock; sequences pll_pwd/pll_rst, filters lock,
// stretches the downstream system reset and retries a bounded number of times.
module pll_lock_ctrl #(
    parameter int unsigned PWD_CYCLES    = 3,
    parameter int unsigned RST_CYCLES    = 3,
    parameter int unsigned LOCK_TIMEOUT  = 2500,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned RST_STRETCH   = 16,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       lock,
    input  logic       restart_req,
    output logic       pll_pwd,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    // One shared phase counter serves PWD, RST, WAIT_LOCK timeout and STABLE stretch.
    localparam int unsigned Max01  = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
    localparam int unsigned Max23  = (LOCK_TIMEOUT > RST_STRETCH) ? LOCK_TIMEOUT : RST_STRETCH;
    localparam int unsigned CntMax = (Max01 > Max23) ? Max01 : Max23;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        StPwd      = 3'd0,
        StRst      = 3'd1,
        StWaitLock = 3'd2,
        StStable   = 3'd3,
        StRun      = 3'd4,
        StFail     = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StabW-1:0]  stab_q, stab_d;
    logic [1:0]        retry_q, retry_d;
    logic              lost_q, lost_d;
    logic              sync1_q, sync2_q;
    logic              lock_s;
    logic              at_max_retry;

    assign lock_s       = sync2_q;
    assign at_max_retry = (retry_q == 2'(MAX_RETRY));

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= lock;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and sticky-flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CntW'(CntMax)) ? cnt_q : cnt_q + CntW'(1);
        stab_d  = '0;
        retry_d = retry_q;
        lost_d  = lost_q;

        unique case (state_q)
            StPwd: begin
                if (cnt_q == CntW'(PWD_CYCLES - 1)) state_d = StRst;
            end
            StRst: begin
                if (cnt_q == CntW'(RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock_s) begin
                    stab_d = (stab_q == StabW'(STABLE_CYCLES)) ? stab_q : stab_q + StabW'(1);
                end
                // A filtered lock wins over a timeout on the same cycle.
                if (stab_q == StabW'(STABLE_CYCLES)) begin
                    state_d = StStable;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                    if (at_max_retry) begin
                        state_d = StFail;
                    end else begin
                        state_d = StPwd;
                        retry_d = retry_q + 2'd1;
                    end
                end
            end
            StStable: begin
                if (!lock_s) begin
                    if (at_max_retry) begin
                        state_d = StFail;
                    end else begin
                        state_d = StPwd;
                        retry_d = retry_q + 2'd1;
                    end
                end else if (cnt_q == CntW'(RST_STRETCH)) begin
                    state_d = StRun;
                    retry_d = 2'd0;
                end
            end
            StRun: begin
                // Loss of lock re-sequences without consuming a retry.
                if (!lock_s) begin
                    state_d = StPwd;
                    lost_d  = 1'b1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StPwd;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end

        if (restart_req) begin
            state_d = StPwd;
            cnt_d   = '0;
            stab_d  = '0;
            retry_d = 2'd0;
            lost_d  = 1'b0;
        end
    end

    // State, counters and registered Moore outputs decoded from the next state.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q   <= StPwd;
            cnt_q     <= '0;
            stab_q    <= '0;
            retry_q   <= 2'd0;
            lost_q    <= 1'b0;
            pll_pwd   <= 1'b1;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            state_dbg <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stab_q    <= stab_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_pwd   <= (state_d == StPwd) || (state_d == StFail);
            pll_rst   <= (state_d == StPwd) || (state_d == StRst) || (state_d == StFail);
            sys_rst   <= (state_d != StRun);
            ready     <= (state_d == StRun);
            fail      <= (state_d == StFail);
            state_dbg <= state_d;
        end
    end

    assign retry_cnt = retry_q;
    assign lock_lost = lost_q;

endmodule
